// File: rtl/debug_err_report_arbiter_if.sv
// Error-report bus between P error sources, the report arbiter and the report consumer.
// master = sources/consumer side, slave = arbiter side.
interface debug_err_report_arbiter_if #(
   parameter int P    = 5,
   parameter int ECw  = 3,
   parameter int CNTw = 8
);
   localparam int Pw = (P > 1) ? $clog2(P) : 1;

   logic [P-1:0]     err_valid;
   logic [P*ECw-1:0] err_code;
   logic             rpt_valid;
   logic             rpt_ready;
   logic [Pw-1:0]    rpt_port;
   logic [ECw-1:0]   rpt_code;
   logic [P-1:0]     ovf_flags;
   logic             any_err;
   logic [CNTw-1:0]  err_count;

   modport master (
      output err_valid, err_code, rpt_ready,
      input  rpt_valid, rpt_port, rpt_code, ovf_flags, any_err, err_count
   );

   modport slave (
      input  err_valid, err_code, rpt_ready,
      output rpt_valid, rpt_port, rpt_code, ovf_flags, any_err, err_count
   );
endinterface

// File: rtl/debug_err_report_arbiter.sv
// Collects one-cycle error pulses from P sources into 1-entry slots and presents them
// one at a time, round-robin, on a valid/ready report port with sticky status flags.
module debug_err_report_arbiter #(
   parameter int P    = 5,
   parameter int ECw  = 3,
   parameter int CNTw = 8
) (
   input logic                       clk,
   input logic                       rst_n,
   input logic                       clr_i,
   debug_err_report_arbiter_if.slave bus
);
   localparam int Pw = (P > 1) ? $clog2(P) : 1;

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_PRESENT = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [P-1:0]          pend_q, pend_d;
   logic [P-1:0][ECw-1:0] code_q, code_d;
   logic [P-1:0]          ovf_q, ovf_d;
   logic                  any_q, any_d;
   logic [CNTw-1:0]       cnt_q, cnt_d;
   logic [Pw-1:0]         ptr_q, ptr_d;
   logic [Pw-1:0]         port_q, port_d;
   logic [ECw-1:0]        rcode_q, rcode_d;

   logic                  hs_s;
   logic                  found_s;
   logic [Pw-1:0]         win_s;
   logic [ECw-1:0]        win_code_s;

   assign hs_s = (state_q == S_PRESENT) && bus.rpt_ready;

   // Round-robin search over pending slots, starting at the pointer
   always_comb begin
      found_s    = 1'b0;
      win_s      = '0;
      win_code_s = '0;
      for (int k = 0; k < P; k++) begin
         int unsigned   sum;
         logic [Pw-1:0] idx;
         sum = (int'(ptr_q) + k) % P;
         idx = Pw'(sum);
         if (!found_s && pend_q[idx]) begin
            found_s    = 1'b1;
            win_s      = idx;
            win_code_s = code_q[idx];
         end else begin
            found_s    = found_s;
         end
      end
   end

   // Slot capture; a drained slot may be refilled on the same edge without overflow
   always_comb begin
      pend_d = pend_q;
      code_d = code_q;
      ovf_d  = ovf_q;
      for (int i = 0; i < P; i++) begin
         if (bus.err_valid[i]) begin
            if (!pend_q[i] || (hs_s && (port_q == Pw'(i)))) begin
               pend_d[i] = 1'b1;
               code_d[i] = bus.err_code[i*ECw +: ECw];
            end else begin
               ovf_d[i] = 1'b1;
            end
         end else if (hs_s && (port_q == Pw'(i))) begin
            pend_d[i] = 1'b0;
         end else begin
            pend_d[i] = pend_q[i];
         end
      end
   end

   // Report FSM, pointer advance and saturating handshake counter
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      port_d  = port_q;
      rcode_d = rcode_q;
      cnt_d   = cnt_q;
      any_d   = any_q | (|bus.err_valid);
      case (state_q)
         S_IDLE: begin
            if (found_s) begin
               state_d = S_PRESENT;
               port_d  = win_s;
               rcode_d = win_code_s;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PRESENT: begin
            if (hs_s) begin
               state_d = S_IDLE;
               ptr_d   = (port_q == Pw'(P - 1)) ? '0 : port_q + Pw'(1);
               if (cnt_q != {CNTw{1'b1}}) begin
                  cnt_d = cnt_q + CNTw'(1);
               end else begin
                  cnt_d = cnt_q;
               end
            end else begin
               state_d = S_PRESENT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; clr wins over every capture and handshake on its edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         code_q  <= '0;
         ovf_q   <= '0;
         any_q   <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         port_q  <= '0;
         rcode_q <= '0;
      end else if (clr_i) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         code_q  <= '0;
         ovf_q   <= '0;
         any_q   <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         port_q  <= '0;
         rcode_q <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         code_q  <= code_d;
         ovf_q   <= ovf_d;
         any_q   <= any_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         port_q  <= port_d;
         rcode_q <= rcode_d;
      end
   end

   assign bus.rpt_valid = (state_q == S_PRESENT);
   assign bus.rpt_port  = port_q;
   assign bus.rpt_code  = rcode_q;
   assign bus.ovf_flags = ovf_q;
   assign bus.any_err   = any_q;
   assign bus.err_count = cnt_q;

`ifndef SYNTHESIS
   a_port_range: assert property (@(posedge clk) disable iff (!rst_n)
      bus.rpt_valid |-> (int'(bus.rpt_port) < P))
      else $error("rpt_port out of range while rpt_valid");

   a_code_stable: assert property (@(posedge clk) disable iff (!rst_n || clr_i)
      (bus.rpt_valid && !bus.rpt_ready) |=> $stable(bus.rpt_code))
      else $error("rpt_code changed while report held under backpressure");
`endif
endmodule

// File: doc/debug_err_report_arbiter.md
DEBUG_ERR_REPORT_ARBITER -- requirements
Module: debug_err_report_arbiter

Interface
REQ-001 Parameter P, default 5: number of error sources (router ports or checkers); P>=2.
REQ-002 Parameter ECw, default 3: error code width per source.
REQ-003 Parameter CNTw, default 8: delivered-report counter width.
REQ-004 Localparam Pw = log2(P); minimum 1.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 clr  in  1  synchronous clear of all state.
REQ-008 err_valid  in  P  per-source error strobe, one-cycle pulse per event.
REQ-009 err_code  in  P*ECw  per-source code; source i occupies bits [i*ECw +: ECw].
REQ-010 rpt_valid  out  1  report available.
REQ-011 rpt_ready  in  1  report consumer accepts.
REQ-012 rpt_port  out  Pw  source index of the current report.
REQ-013 rpt_code  out  ECw  code of the current report.
REQ-014 ovf_flags  out  P  sticky per-source lost-event flags.
REQ-015 any_err  out  1  sticky: set once any err_valid bit has been captured.
REQ-016 err_count  out  CNTw  saturating count of completed report handshakes.

Function
REQ-017 Each source has a 1-entry pending slot (pend bit + ECw code), captured on an edge where err_valid[i]=1.
REQ-018 If err_valid[i]=1 and the slot is full and not being drained that edge, the slot keeps its old code and ovf_flags[i] sets.
REQ-019 If err_valid[i]=1 on the edge where slot i is drained by a handshake, the new code is captured, pend stays 1, and no overflow is flagged.
REQ-020 The FSM has two states, IDLE and PRESENT.
REQ-021 In IDLE with any pend bit set, grant the round-robin winner, register rpt_port/rpt_code from its slot, and go to PRESENT.
REQ-022 In IDLE with no pend bit set, remain in IDLE.
REQ-023 rpt_valid = (state==PRESENT), driven from a register.
REQ-024 Latency: err_valid sampled at edge n gives rpt_valid high after edge n+1 when the FSM is idle and there is no competition.
REQ-025 In PRESENT, rpt_port and rpt_code hold stable until rpt_valid & rpt_ready.
REQ-026 While in PRESENT, a new capture into the granted slot (REQ-018 case) does not alter rpt_code.
REQ-027 On the handshake edge:
 - clear pend of the granted source (subject to REQ-019);
 - increment err_count unless it is at 2^CNTw-1;
 - set the round-robin pointer to granted+1, wrapping P-1 to 0;
 - return to IDLE.
 This leaves at least one idle cycle between reports.
REQ-028 Round-robin search starts at the pointer and proceeds upward with wrap. The pointer resets to 0.
REQ-029 rpt_ready while in IDLE has no effect.
REQ-030 any_err sets on any captured err_valid bit and clears only on reset or clr.
REQ-031 clr=1 on an edge:
 - clears pend, codes, ovf_flags, any_err, err_count and the pointer;
 - forces IDLE with rpt_valid=0;
 - overrides err_valid and any handshake on that same edge.
REQ-032 The block contains simulation-only checks, excluded from synthesis:
 - print an error if rpt_port >= P while rpt_valid=1;
 - print an error if rpt_code changes while rpt_valid=1 and rpt_ready=0.

Reset
REQ-033 Asynchronous assertion of reset (low) immediately forces:
 - rpt_valid=0, rpt_port=0, rpt_code=0;
 - ovf_flags=0, any_err=0, err_count=0;
 - all pend bits 0, pointer 0, state IDLE.
REQ-034 Reset asserted while in PRESENT discards the pending report; no handshake is counted.
REQ-035 Outputs are valid from the first rising edge after reset deasserts.

Verification (P=5, ECw=3, CNTw=8)
REQ-036 Single event: err_valid=5'b00100 with code 3'd6 at edge 1, rpt_ready=1 -> rpt_valid high after edge 2 with rpt_port=2, rpt_code=6; handshake at edge 3; err_count=1.
REQ-037 Fairness: all 5 sources pulse together with codes 1..5 and rpt_ready=1 -> reports arrive in port order 0,1,2,3,4, each separated by one idle cycle; err_count=5.
REQ-038 Backpressure and overflow:
 - source 1 pulses code 2, then code 7 while its report is presented and rpt_ready=0 -> rpt_code stays 2, ovf_flags=5'b00010.
 - after ready: one report only; err_count=1.
REQ-039 Drain-edge refill: source 3 pulses code 4 on the same edge as its handshake -> a second report with port 3, code 4; ovf_flags stays 0.
REQ-040 Saturation and clear:
 - 260 handshakes -> err_count=255.
 - clr pulse together with a new err_valid -> all outputs 0, no report follows.
REQ-041 Async reset mid-PRESENT: reset low between edges -> rpt_valid falls without a clock edge; after release, no stale report.
